pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register, successor to the fixed ID/EX latch. It carries NUM_DATA payload words plus a control vector between two pipeline stages, using a valid/ready handshake. A 2-entry skid buffer keeps full throughput under downstream stall. It also supports synchronous flush (bubble insertion), forces control bits to zero on bubbles, and provides saturating stall/bubble performance counters.

Parameters:
DATA_W, 32, width of one payload word (register data, immediate, instruction).
NUM_DATA, 4, number of payload words per beat.
CTRL_W, 8, width of the control vector (ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ALUOp, ...).
CNT_W, 16, width of each performance counter.

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_i  input  1  reset; asynchronous assert, active-low.
in_valid_i  input  1  upstream beat present.
in_ready_o  output  1  stage can accept a beat; equals NOT skid_valid (registered state only).
in_data_i  input  NUM_DATA*DATA_W  payload; word k at [k*DATA_W +: DATA_W].
in_ctrl_i  input  CTRL_W  control vector.
flush_i  input  1  synchronous kill of all held beats.
out_valid_o  output  1  main entry holds a valid beat.
out_ready_i  input  1  downstream accepts the beat.
out_data_o  output  NUM_DATA*DATA_W  main-entry payload.
out_ctrl_o  output  CTRL_W  main-entry control, ANDed with out_valid_o.
stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.
bubble_cnt_o  output  CNT_W  cycles with out_valid_o=0.

Behaviour:
- Reset (rst_i=0, asynchronous, no clock needed):
  - Main and skid valid bits, data and ctrl all clear to 0.
  - Counters clear to 0.
  - Resulting outputs: out_valid_o=0, out_ctrl_o=0, out_data_o=0, in_ready_o=1.
- Handshakes:
  - Input transfer: in_valid_i & in_ready_o.
  - Output transfer: out_valid_o & out_ready_i.
  - in_valid_i may not depend on in_ready_o.
- State machine (derived from {main_valid, skid_valid}):
  - EMPTY:
    - input transfer -> ONE; main <= input.
  - ONE:
    - input & output -> ONE; main <= input.
    - input only -> FULL; skid <= input.
    - output only -> EMPTY.
    - neither -> hold.
  - FULL (in_ready_o=0, so no input transfer):
    - output -> ONE; main <= skid.
    - else hold.
- Latency and throughput:
  - Latency is 1 cycle from an input transfer into EMPTY to out_valid_o.
  - Sustained throughput is 1 beat/cycle.
  - Beat order is strictly preserved.
- Flush (synchronous, highest priority):
  - On the next edge, main_valid and skid_valid go to 0, giving EMPTY.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle counts as delivered.
  - Data registers may keep stale values; out_ctrl_o is 0 because of the valid gating.
- Bubbles:
  - out_ctrl_o = 0 whenever out_valid_o=0.
  - out_data_o holds the last main value (don't-care to downstream).
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1 (no wrap).
  - Flush does not clear the counters; only reset does.
  - The flush cycle itself is evaluated normally on the pre-flush state.
- Reset mid-operation: all held beats are lost and both counters return to 0; no partial beat is emitted.

Decomposition:
- Package pipe_pkg holds:
  - Enum stage_state_e {EMPTY, ONE, FULL}.
  - Default width constants DATA_W/CTRL_W/CNT_W.
  - Control-vector bit-index constants for ALUSrc, MemToReg, RegWrite, MemWrite, MemRead and the ALUOp field.
- Sub-module sat_counter (CNT_W; inc_i, count_o; same clock/reset), instantiated twice.

Test Plan:
1. Stream: out_ready_i=1; beats ctrl 0x11, 0x22, 0x33 back-to-back -> each appears on out_ctrl_o exactly 1 cycle after acceptance, in order; in_ready_o stays 1; stall_cnt_o=0.
2. Backpressure: out_ready_i=0; send A, B -> in_ready_o falls after B is accepted and C is held upstream; after 5 stall cycles, raise out_ready_i -> A, B, C delivered in order, no gaps; stall_cnt_o=5.
3. Flush in FULL with in_valid_i=1 carrying D -> next cycle out_valid_o=0, out_ctrl_o=0x00, in_ready_o=1; D never appears on output.
4. Bubble zeroing: single beat ctrl=0xFF followed by idle -> out_ctrl_o=0xFF for one cycle, then 0x00; bubble_cnt_o increments every idle cycle.
5. Async reset: pull rst_i low between edges while FULL -> out_valid_o=0, in_ready_o=1, both counters 0 immediately, no clock required.
6. Saturation with CNT_W=4: hold a valid beat with out_ready_i=0 for 20 cycles -> stall_cnt_o=15 and remains 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline-stage skid register.
//   stage_state_e : occupancy of the stage, encoded as {main_valid, skid_valid}
//   DEF_*         : default widths used by the interface and the top
//   CTRL_*        : bit positions inside the control vector
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } stage_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_DATA = 4;
    localparam int DEF_CTRL_W   = 8;
    localparam int DEF_CNT_W    = 16;

    localparam int CTRL_ALUSRC   = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_ALUOP_W  = 3;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: handshake, payload and counter signals of one pipeline stage.
//   slave  : view of the stage itself (accepts upstream beats, drives downstream)
//   master : view of the environment driving the stage
interface pipe_stage_skid_if import pipe_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_DATA = DEF_NUM_DATA,
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int CNT_W    = DEF_CNT_W
) ();
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [NUM_DATA*DATA_W-1:0] in_data_i;
    logic [CTRL_W-1:0]          in_ctrl_i;
    logic                       flush_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [NUM_DATA*DATA_W-1:0] out_data_o;
    logic [CTRL_W-1:0]          out_ctrl_o;
    logic [CNT_W-1:0]           stall_cnt_o;
    logic [CNT_W-1:0]           bubble_cnt_o;

    modport slave (
        input  in_valid_i, in_data_i, in_ctrl_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_ctrl_o, stall_cnt_o, bubble_cnt_o
    );

    modport master (
        output in_valid_i, in_data_i, in_ctrl_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o, stall_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that stops at all-ones instead of wrapping.
//   clk_i   : clock
//   rst_i   : async active-low reset, clears the count
//   inc_i   : count this cycle
//   count_o : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count_o = r_count;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer,
// synchronous flush, bubble control-zeroing and saturating stall/bubble counters.
//   clk_i : clock
//   rst_i : async active-low reset
//   bus   : slave modport of pipe_stage_skid_if (handshakes, payload, ctrl, counters)
//
// state | meaning
// EMPTY | no beat held, output is a bubble
// ONE   | main entry holds the beat on the output
// FULL  | main on output, skid holds the next beat; upstream is stalled
module pipe_stage_skid import pipe_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_DATA = DEF_NUM_DATA,
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_stage_skid_if.slave  bus
);
    localparam int PAY_W = NUM_DATA * DATA_W;

    stage_state_e      r_state;
    stage_state_e      w_state_nxt;
    logic [PAY_W-1:0]  r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [PAY_W-1:0]  r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // State encoding is {main_valid, skid_valid}
    assign w_main_valid = r_state[1];
    assign w_skid_valid = r_state[0];
    assign w_in_xfer    = bus.in_valid_i & ~w_skid_valid;
    assign w_out_xfer   = w_main_valid & bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt    = ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt      = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush wins: everything held is dropped and the incoming beat is not captured
        if (bus.flush_i) begin
            w_state_nxt      = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= bus.in_data_i;
                r_main_ctrl <= bus.in_ctrl_i;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= bus.in_data_i;
                r_skid_ctrl <= bus.in_ctrl_i;
            end
        end
    end

    // Ready depends only on registered state so upstream never sees a comb path
    assign bus.in_ready_o  = ~w_skid_valid;
    assign bus.out_valid_o = w_main_valid;
    assign bus.out_data_o  = r_main_data;
    assign bus.out_ctrl_o  = r_main_ctrl & {CTRL_W{w_main_valid}};

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_main_valid & ~bus.out_ready_i),
        .count_o (bus.stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (~w_main_valid),
        .count_o (bus.bubble_cnt_o)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed, table-driven bench for pipe_stage_skid.
// A default-width instance runs streaming, backpressure, flush, bubble and
// async-reset cases; a CNT_W=4 instance checks counter saturation.
module tb_pipe_stage_skid;
    logic clk;
    logic rst;

    pipe_stage_skid_if                bus ();
    pipe_stage_skid_if #(.CNT_W(4))   sbus ();

    pipe_stage_skid u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    pipe_stage_skid #(.CNT_W(4)) u_sat (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       iv;
        logic [7:0] ic;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic [7:0] oc;
        logic       ir;
        int         s;
        int         b;
    } vec_t;

    vec_t vecs[27];

    function automatic logic [127:0] mkdata(input logic [7:0] c);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = {c, 8'(k), 16'hBEEF};
        return d;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] ic, input logic ordy, input logic fl);
        bus.in_valid_i  = iv;
        bus.in_ctrl_i   = ic;
        bus.in_data_i   = mkdata(ic);
        bus.out_ready_i = ordy;
        bus.flush_i     = fl;
    endtask

    initial begin
        // iv  ic     ordy fl   ov  oc     ir  stall bubble
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 0, 1};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 0, 1};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 0, 1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1};
        vecs[4]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 0, 2};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 2};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 3};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 4};
        vecs[8]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 0, 5};
        vecs[9]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1, 5};
        vecs[10] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 2, 5};
        vecs[11] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 3, 5};
        vecs[12] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 4, 5};
        vecs[13] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 5, 5};
        vecs[14] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b1, 5, 5};
        vecs[15] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 5, 5};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5, 5};
        vecs[17] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 5, 6};
        vecs[18] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 6, 6};
        vecs[19] = '{1'b1, 8'hDD, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 7, 6};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7, 7};
        vecs[21] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 7, 8};
        vecs[22] = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 7, 8};
        vecs[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7, 9};
        vecs[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7, 10};
        vecs[25] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 7, 11};
        vecs[26] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 8, 11};

        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        sbus.in_valid_i  = 1'b0;
        sbus.in_ctrl_i   = 8'h00;
        sbus.in_data_i   = '0;
        sbus.out_ready_i = 1'b1;
        sbus.flush_i     = 1'b0;
        #2;
        chk("reset out_valid",  bus.out_valid_o, 1'b0);
        chk("reset in_ready",   bus.in_ready_o, 1'b1);
        chk("reset out_ctrl",   bus.out_ctrl_o, 8'h00);
        chk("reset out_data",   bus.out_data_o, 128'h0);
        chk("reset stall_cnt",  bus.stall_cnt_o, 16'd0);
        chk("reset bubble_cnt", bus.bubble_cnt_o, 16'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].iv, vecs[i].ic, vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), bus.out_valid_o, vecs[i].ov);
            chk($sformatf("v%0d out_ctrl", i),  bus.out_ctrl_o,  vecs[i].oc);
            chk($sformatf("v%0d in_ready", i),  bus.in_ready_o,  vecs[i].ir);
            chk($sformatf("v%0d stall_cnt", i), bus.stall_cnt_o, 16'(vecs[i].s));
            chk($sformatf("v%0d bubble_cnt", i), bus.bubble_cnt_o, 16'(vecs[i].b));
            if (vecs[i].ov)
                chk($sformatf("v%0d out_data", i), bus.out_data_o, mkdata(vecs[i].oc));
        end

        // Stage is FULL here; reset between edges must clear everything immediately
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #3 rst = 1'b0;
        #1;
        chk("async rst out_valid",  bus.out_valid_o, 1'b0);
        chk("async rst in_ready",   bus.in_ready_o, 1'b1);
        chk("async rst out_ctrl",   bus.out_ctrl_o, 8'h00);
        chk("async rst stall_cnt",  bus.stall_cnt_o, 16'd0);
        chk("async rst bubble_cnt", bus.bubble_cnt_o, 16'd0);
        chk("async rst out_data",   bus.out_data_o, 128'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        drive(1'b1, 8'h66, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post rst out_valid",  bus.out_valid_o, 1'b1);
        chk("post rst out_ctrl",   bus.out_ctrl_o, 8'h66);
        chk("post rst bubble_cnt", bus.bubble_cnt_o, 16'd1);

        sbus.in_valid_i  = 1'b1;
        sbus.in_ctrl_i   = 8'h5A;
        sbus.in_data_i   = mkdata(8'h5A);
        sbus.out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        sbus.in_valid_i = 1'b0;
        chk("sat out_valid", sbus.out_valid_o, 1'b1);
        chk("sat out_ctrl",  sbus.out_ctrl_o, 8'h5A);
        repeat (20) @(posedge clk);
        #1;
        chk("sat stall_cnt 20",  sbus.stall_cnt_o, 4'd15);
        chk("sat bubble_cnt",    sbus.bubble_cnt_o, 4'd2);
        repeat (5) @(posedge clk);
        #1;
        chk("sat stall_cnt held", sbus.stall_cnt_o, 4'd15);
        chk("sat out_ctrl held",  sbus.out_ctrl_o, 8'h5A);
        chk("sat in_ready",       sbus.in_ready_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
